// File: rtl/fp_align_shifter_pkg.sv
// Shared types and helpers for the FP mantissa alignment shifter.
package fp_align_shifter_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_t;

  // Magnitude of a sign-extended exponent difference; the most negative
  // EXP_W value maps to 2^(EXP_W-1), which still fits unsigned in EXP_W bits.
  function automatic logic [31:0] abs_diff(input logic signed [31:0] d);
    return (d < 0) ? 32'(-d) : 32'(d);
  endfunction

endpackage

// File: rtl/fp_align_shifter_if.sv
// Valid/ready beat interface between exponent compare, shifter and mantissa adder.
interface fp_align_shifter_if
  import fp_align_shifter_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic              in_hidden;
  logic [EXP_W-1:0]  in_exp_diff;
  logic              in_round;
  rnd_mode_t         in_rnd_mode;
  logic              in_sign;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic              out_guard;
  logic              out_round;
  logic              out_sticky;
  logic              out_carry;
  logic              out_sat;

  modport master (
    output in_valid, in_mant, in_hidden, in_exp_diff, in_round, in_rnd_mode, in_sign,
    output out_ready,
    input  in_ready,
    input  out_valid, out_mant, out_guard, out_round, out_sticky, out_carry, out_sat
  );

  modport slave (
    input  in_valid, in_mant, in_hidden, in_exp_diff, in_round, in_rnd_mode, in_sign,
    input  out_ready,
    output in_ready,
    output out_valid, out_mant, out_guard, out_round, out_sticky, out_carry, out_sat
  );
endinterface

// File: rtl/fp_align_shifter_sticky_shift.sv
// Combinational right shifter over {hidden, mant, 2'b00} with guard/round/sticky
// extraction and saturation once the whole operand has been shifted out.
module fp_sticky_shift #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic [MANT_W+2:0] w,
  input  logic [EXP_W-1:0]  amt,
  output logic [MANT_W-1:0] y_mant,
  output logic              g,
  output logic              r,
  output logic              s,
  output logic              sat
);
  localparam int N = MANT_W + 3;

  logic [N-1:0] lost_mask;

  always_comb begin
    y_mant    = '0;
    g         = 1'b0;
    r         = 1'b0;
    s         = 1'b0;
    sat       = 1'b0;
    lost_mask = ~({N{1'b1}} << amt);
    if (int'(amt) >= N) begin
      sat = 1'b1;
      s   = |w;
    end else begin
      // top bit of the shifted word is never part of the result for amt>=1
      {y_mant, g, r} = (N-1)'(w >> amt);
      s = |(w & lost_mask);
    end
  end
endmodule

// File: rtl/fp_align_shifter.sv
// Two-stage valid/ready mantissa alignment shifter with optional in-place
// directed rounding; stage 1 captures |exp_diff|, stage 2 shifts and rounds.
module fp_align_shifter
  import fp_align_shifter_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_align_shifter_if.slave  bus
);
  logic              s1_valid, s1_hidden, s1_round, s1_sign;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_amt;
  rnd_mode_t         s1_mode;
  logic              s1_rdy, s2_rdy;

  logic signed [31:0] diff_ext;
  logic [MANT_W-1:0]  sh_mant;
  logic               sh_g, sh_r, sh_s, sh_sat;
  logic               inc, do_round;
  logic [MANT_W:0]    rnd_sum;

  logic              o_valid, o_guard, o_round, o_sticky, o_carry, o_sat;
  logic [MANT_W-1:0] o_mant;

  assign s2_rdy       = ~o_valid | bus.out_ready;
  assign s1_rdy       = ~s1_valid | s2_rdy;
  assign bus.in_ready = s1_rdy;

  assign diff_ext = {{(32-EXP_W){bus.in_exp_diff[EXP_W-1]}}, bus.in_exp_diff};

  fp_sticky_shift #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_shift (
    .w      ({s1_hidden, s1_mant, 2'b00}),
    .amt    (s1_amt),
    .y_mant (sh_mant),
    .g      (sh_g),
    .r      (sh_r),
    .s      (sh_s),
    .sat    (sh_sat)
  );

  always_comb begin
    inc = 1'b0;
    case (s1_mode)
      RND_RNE: inc = sh_g & (sh_r | sh_s | sh_mant[0]);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = (sh_g | sh_r | sh_s) & ~s1_sign;
      RND_RDN: inc = (sh_g | sh_r | sh_s) & s1_sign;
      default: inc = 1'b0;
    endcase
  end

  // amt==0 is a pure pass-through, never rounded
  assign do_round = s1_round & (s1_amt != '0);
  assign rnd_sum  = {1'b0, sh_mant} + {{MANT_W{1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_hidden <= 1'b0;
      s1_round  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mant   <= '0;
      s1_amt    <= '0;
      s1_mode   <= RND_RNE;
      o_valid   <= 1'b0;
      o_mant    <= '0;
      o_guard   <= 1'b0;
      o_round   <= 1'b0;
      o_sticky  <= 1'b0;
      o_carry   <= 1'b0;
      o_sat     <= 1'b0;
    end else begin
      if (s1_rdy) s1_valid <= bus.in_valid;
      if (bus.in_valid && s1_rdy) begin
        s1_amt    <= EXP_W'(abs_diff(diff_ext));
        s1_mant   <= bus.in_mant;
        s1_hidden <= bus.in_hidden;
        s1_round  <= bus.in_round;
        s1_mode   <= bus.in_rnd_mode;
        s1_sign   <= bus.in_sign;
      end
      if (s2_rdy) o_valid <= s1_valid;
      if (s1_valid && s2_rdy) begin
        o_sat <= sh_sat;
        if (do_round) begin
          o_mant   <= rnd_sum[MANT_W-1:0];
          o_carry  <= rnd_sum[MANT_W];
          o_guard  <= 1'b0;
          o_round  <= 1'b0;
          o_sticky <= 1'b0;
        end else begin
          o_mant   <= sh_mant;
          o_carry  <= 1'b0;
          o_guard  <= sh_g;
          o_round  <= sh_r;
          o_sticky <= sh_s;
        end
      end
    end
  end

  assign bus.out_valid  = o_valid;
  assign bus.out_mant   = o_mant;
  assign bus.out_guard  = o_guard;
  assign bus.out_round  = o_round;
  assign bus.out_sticky = o_sticky;
  assign bus.out_carry  = o_carry;
  assign bus.out_sat    = o_sat;
endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter (MANT_W=23, EXP_W=8).
module tb_fp_align_shifter;
  import fp_align_shifter_pkg::*;

  typedef struct packed {
    logic [22:0] mant;
    logic        grd;
    logic        rnd;
    logic        stk;
    logic        cy;
    logic        sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_align_shifter_if #(.MANT_W(23), .EXP_W(8)) bus();
  fp_align_shifter #(.MANT_W(23), .EXP_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  bit   rand_rdy = 1'b0;
  res_t pend;
  res_t exp_q[$];
  res_t obs_q[$];
  int   exp_cyc[$];
  int   obs_cyc[$];

  function automatic res_t mk(logic [22:0] m, logic g, logic r, logic s, logic c, logic sat);
    res_t v;
    v.mant = m; v.grd = g; v.rnd = r; v.stk = s; v.cy = c; v.sat = sat;
    return v;
  endfunction

  // Reference: bit-level arithmetic on the 24-bit significand
  function automatic res_t model(logic h, logic [22:0] m, logic [7:0] d, logic rd,
                                 logic [1:0] mode, logic sg);
    res_t        v;
    logic [63:0] x;
    int          amt;
    logic        inc;
    logic [23:0] sum;
    x   = 64'({h, m});
    amt = d[7] ? 256 - int'(d) : int'(d);
    v   = '0;
    if (amt == 0) v.mant = m;
    else if (amt >= 26) begin
      v.stk = (x != 64'd0);
      v.sat = 1'b1;
    end else begin
      v.mant = 23'(x >> amt);
      v.grd  = x[amt-1];
      v.rnd  = (amt >= 2) ? x[amt-2] : 1'b0;
      v.stk  = (amt >= 3) ? ((x & ((64'd1 << (amt-2)) - 64'd1)) != 64'd0) : 1'b0;
    end
    if (rd && amt != 0) begin
      case (mode)
        2'd0:    inc = v.grd & (v.rnd | v.stk | v.mant[0]);
        2'd1:    inc = 1'b0;
        2'd2:    inc = (v.grd | v.rnd | v.stk) & ~sg;
        default: inc = (v.grd | v.rnd | v.stk) & sg;
      endcase
      sum   = {1'b0, v.mant} + 24'(inc);
      v.mant = sum[22:0];
      v.cy   = sum[23];
      v.grd  = 1'b0;
      v.rnd  = 1'b0;
      v.stk  = 1'b0;
    end
    return v;
  endfunction

  task automatic cycle(output bit acc);
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      exp_q.push_back(pend);
      exp_cyc.push_back(cyc_n);
    end
    if (bus.out_valid && bus.out_ready) begin
      obs_q.push_back({bus.out_mant, bus.out_guard, bus.out_round, bus.out_sticky,
                       bus.out_carry, bus.out_sat});
      obs_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drive(logic h, logic [22:0] m, logic [7:0] d, logic rd, logic [1:0] mode,
                       logic sg, res_t e);
    bus.in_valid    = 1'b1;
    bus.in_hidden   = h;
    bus.in_mant     = m;
    bus.in_exp_diff = d;
    bus.in_round    = rd;
    bus.in_rnd_mode = rnd_mode_t'(mode);
    bus.in_sign     = sg;
    pend            = e;
  endtask

  task automatic send(logic h, logic [22:0] m, logic [7:0] d, logic rd, logic [1:0] mode,
                      logic sg, res_t e);
    bit acc;
    acc = 1'b0;
    drive(h, m, d, rd, mode, sg, e);
    for (int i = 0; i < 50 && !acc; i++) cycle(acc);
    bus.in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send accept: in_ready never high for diff=%h", d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.in_ready, bus.out_mant, bus.out_guard, bus.out_round,
         bus.out_sticky, bus.out_carry, bus.out_sat} !== {2'b01, 28'd0}) begin
      bad++;
      $display("FAIL reset state: got v=%b rdy=%b mant=%h want v=0 rdy=1 mant=0",
               bus.out_valid, bus.in_ready, bus.out_mant);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_shift();
    res_t e, o;
    int   ec, oc;
    send(1'b1, 23'h000000, 8'h01, 1'b0, 2'd0, 1'b0, mk(23'h400000, 0, 0, 0, 0, 0));
    send(1'b1, 23'h000003, 8'hFD, 1'b0, 2'd0, 1'b0, mk(23'h100000, 0, 1, 1, 0, 0));
    send(1'b1, 23'h000001, 8'd25, 1'b0, 2'd0, 1'b0, model(1'b1, 23'h000001, 8'd25, 1'b0, 2'd0, 1'b0));
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      ec = exp_cyc.pop_front(); oc = obs_cyc.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL shift beat: got %h want %h", o, e); end
      total++;
      if (oc - ec !== 2) begin bad++; $display("FAIL shift latency: got %0d want 2", oc - ec); end
    end
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL shift count: pending exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
  endtask

  task automatic test_rounding();
    res_t e, o;
    send(1'b1, 23'h000003, 8'h01, 1'b1, 2'd0, 1'b0, mk(23'h400002, 0, 0, 0, 0, 0));
    send(1'b1, 23'h000001, 8'h01, 1'b1, 2'd0, 1'b0, mk(23'h400000, 0, 0, 0, 0, 0));
    send(1'b1, 23'h7FFFFF, 8'h01, 1'b1, 2'd2, 1'b0, mk(23'h000000, 0, 0, 0, 1, 0));
    send(1'b1, 23'h7FFFFF, 8'h01, 1'b1, 2'd2, 1'b1, mk(23'h7FFFFF, 0, 0, 0, 0, 0));
    send(1'b1, 23'h7FFFFF, 8'h01, 1'b1, 2'd3, 1'b1, mk(23'h000000, 0, 0, 0, 1, 0));
    send(1'b1, 23'h7FFFFF, 8'h01, 1'b1, 2'd1, 1'b1, mk(23'h7FFFFF, 0, 0, 0, 0, 0));
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      void'(exp_cyc.pop_front()); void'(obs_cyc.pop_front());
      total++;
      if (o !== e) begin bad++; $display("FAIL round beat: got %h want %h", o, e); end
    end
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL round count: pending exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
  endtask

  task automatic test_saturate();
    res_t e, o;
    send(1'b1, 23'h000005, 8'h40, 1'b0, 2'd0, 1'b0, mk(23'h000000, 0, 0, 1, 0, 1));
    send(1'b1, 23'h000005, 8'h80, 1'b0, 2'd0, 1'b0, mk(23'h000000, 0, 0, 1, 0, 1));
    send(1'b1, 23'h000005, 8'h00, 1'b1, 2'd2, 1'b0, mk(23'h000005, 0, 0, 0, 0, 0));
    send(1'b1, 23'h000005, 8'hE6, 1'b0, 2'd0, 1'b0, mk(23'h000000, 0, 0, 1, 0, 1));
    send(1'b0, 23'h000000, 8'd30, 1'b0, 2'd0, 1'b0, mk(23'h000000, 0, 0, 0, 0, 1));
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      void'(exp_cyc.pop_front()); void'(obs_cyc.pop_front());
      total++;
      if (o !== e) begin bad++; $display("FAIL sat beat: got %h want %h", o, e); end
    end
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL sat count: pending exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
  endtask

  task automatic test_back_to_back();
    res_t e, o, ea;
    bit   acc;
    logic [22:0] ma, mb, mc;
    ma = 23'h123456; mb = 23'h0ABCDE; mc = 23'h7F0001;
    ea = model(1'b1, ma, 8'd4, 1'b0, 2'd0, 1'b0);
    bus.out_ready = 1'b0;
    drive(1'b1, ma, 8'd4, 1'b0, 2'd0, 1'b0, ea);
    cycle(acc);
    drive(1'b1, mb, 8'hF9, 1'b1, 2'd0, 1'b0, model(1'b1, mb, 8'hF9, 1'b1, 2'd0, 1'b0));
    cycle(acc);
    drive(1'b1, mc, 8'd2, 1'b1, 2'd3, 1'b1, model(1'b1, mc, 8'd2, 1'b1, 2'd3, 1'b1));
    cycle(acc);
    total++;
    if (acc !== 1'b0 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL b2b accept: third acc=%b queued=%0d want 0 2", acc, exp_q.size());
    end
    idle(3);
    total++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
        {bus.out_mant, bus.out_guard, bus.out_round, bus.out_sticky, bus.out_carry,
         bus.out_sat} !== ea) begin
      bad++;
      $display("FAIL b2b hold: rdy=%b v=%b mant=%h want rdy=0 v=1 mant=%h",
               bus.in_ready, bus.out_valid, bus.out_mant, ea.mant);
    end
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) cycle(acc);
    bus.in_valid = 1'b0;
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      void'(exp_cyc.pop_front()); void'(obs_cyc.pop_front());
      total++;
      if (o !== e) begin bad++; $display("FAIL b2b order: got %h want %h", o, e); end
    end
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL b2b count: pending exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();

    // reset with two beats in flight and downstream stalled
    bus.out_ready = 1'b0;
    send(1'b1, 23'h055555, 8'd3, 1'b0, 2'd0, 1'b0, mk(23'h0, 0, 0, 0, 0, 0));
    send(1'b1, 23'h02AAAA, 8'd5, 1'b0, 2'd0, 1'b0, mk(23'h0, 0, 0, 0, 0, 0));
    idle(1);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset: v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    exp_q.delete(); exp_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(6);
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL midreset stale: got %0d beats want 0", obs_q.size());
    end
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_random();
    res_t e, o;
    logic        h, rd, sg;
    logic [22:0] m;
    logic [7:0]  d;
    logic [1:0]  md;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      h  = 1'($urandom_range(0, 7) != 0);
      m  = 23'($urandom);
      d  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 28)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) d = -d;
      rd = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      send(h, m, d, rd, md, sg, model(h, m, d, rd, md, sg));
    end
    idle(20);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      void'(exp_cyc.pop_front()); void'(obs_cyc.pop_front());
      total++;
      if (o !== e) begin bad++; $display("FAIL random beat: got %h want %h", o, e); end
    end
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL random count: pending exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); exp_cyc.delete(); obs_cyc.delete();
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_hidden   = 1'b0;
    bus.in_mant     = '0;
    bus.in_exp_diff = '0;
    bus.in_round    = 1'b0;
    bus.in_rnd_mode = RND_RNE;
    bus.in_sign     = 1'b0;
    bus.out_ready   = 1'b1;
    pend            = '0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_rounding();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
